// File: rtl/rpn_calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rpn_calc_pkg
//  Purpose  : Op-code enumeration and per-op stack requirements for rpn_calc.
//  Revision : 1.0  initial release
// ============================================================================
package rpn_calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_NEG  = 3'd3,
        OP_POP  = 3'd4,
        OP_PUSH = 3'd5,
        OP_DUP  = 3'd6,
        OP_SWAP = 3'd7
    } op_e;

    // Minimum entry count each op needs, indexed by op code.
    localparam logic [1:0] c_min_depth [8] = '{2'd2, 2'd2, 2'd2, 2'd1,
                                               2'd1, 2'd0, 2'd1, 2'd2};

    // Ops that grow the stack and therefore need a free slot (PUSH, DUP).
    localparam logic [7:0] c_needs_slot = 8'b0110_0000;

    function automatic logic is_arith(input op_e i_op);
        return (i_op == OP_ADD) || (i_op == OP_SUB) ||
               (i_op == OP_MUL) || (i_op == OP_NEG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rpn_alu.sv
`default_nettype none
// ============================================================================
//  Module   : rpn_alu
//  Purpose  : Combinational ADD/SUB/MUL/NEG with signed range check and
//             optional saturation.
//  Revision : 1.0  initial release
// ============================================================================
module rpn_alu
    import rpn_calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SAT   = 0
) (
    input  op_e                     i_op,
    input  logic signed [WIDTH-1:0] i_tos,
    input  logic signed [WIDTH-1:0] i_nos,
    output logic signed [WIDTH-1:0] o_result,
    output logic                    o_ovf
);

    localparam logic signed [WIDTH-1:0] c_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] w_tos_x;
    logic signed [2*WIDTH-1:0] w_nos_x;
    logic signed [2*WIDTH-1:0] w_full;
    logic        [WIDTH:0]     w_hi;
    logic                      w_oor;

    // A 2*WIDTH workspace holds every exact result, including the MUL product.
    assign w_tos_x = {{WIDTH{i_tos[WIDTH-1]}}, i_tos};
    assign w_nos_x = {{WIDTH{i_nos[WIDTH-1]}}, i_nos};

    always_comb begin
        w_full = w_tos_x;
        case (i_op)
            OP_ADD:  w_full = w_nos_x + w_tos_x;
            OP_SUB:  w_full = w_nos_x - w_tos_x;
            OP_MUL:  w_full = w_nos_x * w_tos_x;
            OP_NEG:  w_full = '0 - w_tos_x;
            default: w_full = w_tos_x;
        endcase
    end

    // In range only when the bits above the result sign all copy it.
    assign w_hi  = w_full[2*WIDTH-1:WIDTH-1];
    assign w_oor = is_arith(i_op) && !((&w_hi) || !(|w_hi));

    always_comb begin
        o_ovf    = w_oor;
        o_result = w_full[WIDTH-1:0];
        if ((SAT != 0) && w_oor) begin
            o_result = w_full[2*WIDTH-1] ? c_min : c_max;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rpn_calc.sv
`default_nettype none
// ============================================================================
//  Module   : rpn_calc
//  Purpose  : Single-cycle RPN calculator over a DEPTH-entry register stack.
//  Revision : 1.0  initial release
// ============================================================================
module rpn_calc
    import rpn_calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int SAT   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [WIDTH-1:0]      in,
    input  logic [2:0]                   op,
    input  logic                         apply,
    output logic signed [WIDTH-1:0]      tail,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         valid,
    output logic                         ovf
);

    localparam int DW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic signed [WIDTH-1:0] r_stack     [DEPTH];
    logic signed [WIDTH-1:0] w_stack_nxt [DEPTH];
    logic [DW-1:0]           r_depth;
    logic [DW-1:0]           w_depth_nxt;
    logic                    r_valid;
    logic                    w_valid_nxt;
    logic                    r_ovf;
    logic                    w_ovf_nxt;

    op_e                     w_op;
    logic [DW-1:0]           w_tos_i;
    logic [DW-1:0]           w_nos_i;
    logic [AW-1:0]           w_slot_i;
    logic signed [WIDTH-1:0] w_tos;
    logic signed [WIDTH-1:0] w_nos;
    logic signed [WIDTH-1:0] w_alu_res;
    logic                    w_alu_ovf;
    logic                    w_accept;

    assign w_op     = op_e'(op);
    assign w_tos_i  = r_depth - DW'(1);
    assign w_nos_i  = r_depth - DW'(2);
    assign w_slot_i = r_depth[AW-1:0];

    // Guard the reads so an empty/shallow stack shows zero, not stale data.
    assign w_tos = (r_depth >= DW'(1)) ? r_stack[w_tos_i[AW-1:0]] : '0;
    assign w_nos = (r_depth >= DW'(2)) ? r_stack[w_nos_i[AW-1:0]] : '0;

    assign w_accept = (r_depth >= DW'(c_min_depth[op])) &&
                      !(c_needs_slot[op] && (r_depth == DW'(DEPTH)));

    rpn_alu #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_alu (
        .i_op     (w_op),
        .i_tos    (w_tos),
        .i_nos    (w_nos),
        .o_result (w_alu_res),
        .o_ovf    (w_alu_ovf)
    );

    always_comb begin
        w_stack_nxt = r_stack;
        w_depth_nxt = r_depth;
        w_valid_nxt = r_valid;
        w_ovf_nxt   = r_ovf;
        if (apply) begin
            w_valid_nxt = w_accept;
            if (w_accept) begin
                w_ovf_nxt = w_alu_ovf;
                case (w_op)
                    OP_ADD, OP_SUB, OP_MUL: begin
                        w_stack_nxt[w_nos_i[AW-1:0]] = w_alu_res;
                        w_depth_nxt                  = r_depth - DW'(1);
                    end
                    OP_NEG:  w_stack_nxt[w_tos_i[AW-1:0]] = w_alu_res;
                    OP_POP:  w_depth_nxt = r_depth - DW'(1);
                    OP_PUSH: begin
                        w_stack_nxt[w_slot_i] = in;
                        w_depth_nxt           = r_depth + DW'(1);
                    end
                    OP_DUP: begin
                        w_stack_nxt[w_slot_i] = w_tos;
                        w_depth_nxt           = r_depth + DW'(1);
                    end
                    OP_SWAP: begin
                        w_stack_nxt[w_tos_i[AW-1:0]] = w_nos;
                        w_stack_nxt[w_nos_i[AW-1:0]] = w_tos;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
            r_depth <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_stack <= w_stack_nxt;
            r_depth <= w_depth_nxt;
            r_valid <= w_valid_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign tail  = w_tos;
    assign empty = (r_depth == '0);
    assign full  = (r_depth == DW'(DEPTH));
    assign depth = r_depth;
    assign valid = r_valid;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rpn_calc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rpn_calc
//  Purpose  : Scoreboard bench; wrapping and saturating instances share stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rpn_calc;

    localparam logic [2:0] c_add  = 3'd0;
    localparam logic [2:0] c_sub  = 3'd1;
    localparam logic [2:0] c_mul  = 3'd2;
    localparam logic [2:0] c_neg  = 3'd3;
    localparam logic [2:0] c_pop  = 3'd4;
    localparam logic [2:0] c_push = 3'd5;
    localparam logic [2:0] c_dup  = 3'd6;
    localparam logic [2:0] c_swap = 3'd7;

    typedef struct {
        string name;
        int    tail_w;
        int    tail_s;
        int    dep;
        bit    vld;
        bit    ovf_w;
        bit    ovf_s;
    } exp_t;

    logic              clk;
    logic              rst;
    logic signed [7:0] in;
    logic [2:0]        op;
    logic              apply;

    logic signed [7:0] tail_w, tail_s;
    logic              empty_w, empty_s, full_w, full_s;
    logic [2:0]        depth_w, depth_s;
    logic              valid_w, valid_s, ovf_w, ovf_s;

    exp_t  exp_q [$];
    event  ev_check;
    int    n_checks = 0;
    int    n_errors = 0;

    rpn_calc #(.WIDTH(8), .DEPTH(4), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .in(in), .op(op), .apply(apply),
        .tail(tail_w), .empty(empty_w), .full(full_w), .depth(depth_w),
        .valid(valid_w), .ovf(ovf_w)
    );

    rpn_calc #(.WIDTH(8), .DEPTH(4), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .in(in), .op(op), .apply(apply),
        .tail(tail_s), .empty(empty_s), .full(full_s), .depth(depth_s),
        .valid(valid_s), .ovf(ovf_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input string fld, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
        end
    endtask

    task automatic check_entry(input exp_t e);
        chk(e.name, "wrap.tail",  int'(tail_w),  e.tail_w);
        chk(e.name, "wrap.depth", int'(depth_w), e.dep);
        chk(e.name, "wrap.empty", int'(empty_w), int'(e.dep == 0));
        chk(e.name, "wrap.full",  int'(full_w),  int'(e.dep == 4));
        chk(e.name, "wrap.valid", int'(valid_w), int'(e.vld));
        chk(e.name, "wrap.ovf",   int'(ovf_w),   int'(e.ovf_w));
        chk(e.name, "sat.tail",   int'(tail_s),  e.tail_s);
        chk(e.name, "sat.depth",  int'(depth_s), e.dep);
        chk(e.name, "sat.empty",  int'(empty_s), int'(e.dep == 0));
        chk(e.name, "sat.full",   int'(full_s),  int'(e.dep == 4));
        chk(e.name, "sat.valid",  int'(valid_s), int'(e.vld));
        chk(e.name, "sat.ovf",    int'(ovf_s),   int'(e.ovf_s));
    endtask

    // Monitor: after every rising edge (or an async-reset probe) pop one expectation.
    initial begin
        forever begin
            @(posedge clk or ev_check);
            #1;
            if (exp_q.size() > 0) check_entry(exp_q.pop_front());
        end
    end

    task automatic expect_(input string nm, input int tw, input int ts, input int d,
                           input bit v, input bit ow, input bit os);
        exp_t e;
        e.name = nm; e.tail_w = tw; e.tail_s = ts; e.dep = d;
        e.vld = v; e.ovf_w = ow; e.ovf_s = os;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] o, input int v, input string nm,
                         input int tw, input int ts, input int d,
                         input bit vld, input bit ow, input bit os);
        @(negedge clk);
        rst   = 1'b0;
        apply = 1'b1;
        op    = o;
        in    = 8'(v);
        expect_(nm, tw, ts, d, vld, ow, os);
    endtask

    task automatic idle(input string nm, input int tw, input int ts, input int d,
                        input bit vld, input bit ow, input bit os);
        @(negedge clk);
        rst   = 1'b0;
        apply = 1'b0;
        op    = c_push;
        in    = 8'sd99;
        expect_(nm, tw, ts, d, vld, ow, os);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; apply = 1'b0; op = 3'd0; in = '0;

        // Reset dominates a PUSH presented on the same edge.
        @(negedge clk);
        apply = 1'b1; op = c_push; in = 8'sd29;
        expect_("rst_push", 0, 0, 0, 0, 0, 0);

        issue(c_push, 62, "push62", 62, 62, 1, 1, 0, 0);
        issue(c_push, 12, "push12", 12, 12, 2, 1, 0, 0);
        issue(c_add,   0, "add74",  74, 74, 1, 1, 0, 0);
        issue(c_pop,   0, "pop_a",   0,  0, 0, 1, 0, 0);

        issue(c_pop,   0, "pop_empty", 0, 0, 0, 0, 0, 0);
        issue(c_push,  5, "push5",     5, 5, 1, 1, 0, 0);
        issue(c_add,   0, "add_short", 5, 5, 1, 0, 0, 0);
        issue(c_pop,   0, "pop_b",     0, 0, 0, 1, 0, 0);

        issue(c_push, 100, "push100",  100, 100, 1, 1, 0, 0);
        issue(c_push,  50, "push50",    50,  50, 2, 1, 0, 0);
        issue(c_add,    0, "add_ovf", -106, 127, 1, 1, 1, 1);
        idle("idle_hold",             -106, 127, 1, 1, 1, 1);
        issue(c_push,   1, "push1_clr",  1,   1, 2, 1, 0, 0);
        issue(c_pop,    0, "pop_c",   -106, 127, 1, 1, 0, 0);
        issue(c_pop,    0, "pop_d",      0,   0, 0, 1, 0, 0);

        issue(c_push, 1, "fill1", 1, 1, 1, 1, 0, 0);
        issue(c_push, 2, "fill2", 2, 2, 2, 1, 0, 0);
        issue(c_push, 3, "fill3", 3, 3, 3, 1, 0, 0);
        issue(c_push, 4, "fill4", 4, 4, 4, 1, 0, 0);
        issue(c_push, 9, "push_full", 4, 4, 4, 0, 0, 0);
        issue(c_dup,  0, "dup_full",  4, 4, 4, 0, 0, 0);
        issue(c_pop,  0, "pop_full",  3, 3, 3, 1, 0, 0);

        // Asynchronous reset between edges, observed before the next rising edge.
        @(negedge clk);
        apply = 1'b0;
        #1 rst = 1'b1;
        expect_("async_rst", 0, 0, 0, 0, 0, 0);
        -> ev_check;
        #2;
        issue(c_push, 2, "push_after_rst", 2, 2, 1, 1, 0, 0);
        issue(c_pop,  0, "pop_e",          0, 0, 0, 1, 0, 0);

        issue(c_push, -5, "push_m5",  -5,  -5, 1, 1, 0, 0);
        issue(c_push,  2, "push_2",    2,   2, 2, 1, 0, 0);
        issue(c_mul,   0, "mul_m10", -10, -10, 1, 1, 0, 0);
        issue(c_push, 15, "push15",   15,  15, 2, 1, 0, 0);
        issue(c_swap,  0, "swap",    -10, -10, 2, 1, 0, 0);
        issue(c_sub,   0, "sub25",    25,  25, 1, 1, 0, 0);
        issue(c_push, -128, "push_min", -128, -128, 2, 1, 0, 0);
        issue(c_neg,   0, "neg_min",  -128,  127, 2, 1, 1, 1);
        issue(c_mul,   0, "mul_ovf",  -128,  127, 1, 1, 1, 1);
        issue(c_swap,  0, "swap_rej", -128,  127, 1, 0, 1, 1);
        issue(c_pop,   0, "pop_f",       0,    0, 0, 1, 0, 0);

        issue(c_push, -100, "push_m100", -100, -100, 1, 1, 0, 0);
        issue(c_push,  100, "push_p100",  100,  100, 2, 1, 0, 0);
        issue(c_sub,     0, "sub_neg_ovf",  56, -128, 1, 1, 1, 1);
        issue(c_dup,     0, "dup",          56, -128, 2, 1, 0, 0);
        issue(c_add,     0, "add_split",   112, -128, 1, 1, 0, 1);

        @(negedge clk);
        apply = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
